uart_rx_deser: RTL and testbench

- UART receive deserialiser for the APB-UART bridge.
- Runs entirely in the UCLK domain: oversamples the serial RxD line, assembles 8N1 frames LSB first and pushes each good byte into the RX FIFO write port.
- The bridge reads that FIFO from the PCLK side.
- Sticky status bits (framing error, overrun, parity error) feed the bridge State register.

---
 rtl/uart_rx_deser_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_rx_deser.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_rx_deser.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_deser_pkg.sv
// Shared definitions for the UART receive deserialiser: RX FSM encodings,
// default oversample ratio and bridge State/Cntrl register bit positions.
package uart_rx_deser_pkg;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_t;

    localparam int RX_OVERSAMPLE_DEF = 16;

    // Bridge State register bit positions of the sticky receive flags
    localparam int ST_FRAME_ERR_BIT  = 0;
    localparam int ST_OVERRUN_BIT    = 1;
    localparam int ST_PARITY_ERR_BIT = 2;

    localparam int CNTRL_RXEN_BIT = 1;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every i_div+1 cycles while enabled.
// Shared between the RX deserialiser and the TX serialiser.
module uart_baud_tick #(
    parameter int DIV_W = 20
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_hit;

    assign w_hit  = (r_cnt == i_div);
    assign o_tick = i_en & w_hit;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (!i_en || w_hit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserialiser (UCLK domain): oversamples RxD, assembles LSB-first
// frames and pushes good bytes to the RX FIFO. Parity support: UART_RX_PARITY_EN.
module uart_rx_deser
    import uart_rx_deser_pkg::*;
#(
    parameter int DATA_BITS      = 8,
    parameter int OVERSAMPLE     = RX_OVERSAMPLE_DEF,
    parameter int BAUD_DIV_WIDTH = 20
) (
    input  logic                      UCLK,
    input  logic                      reset,
    input  logic                      RxEn,
    input  logic [BAUD_DIV_WIDTH-1:0] BaudDiv,
    input  logic                      RxD,
    input  logic                      RxFull,
    input  logic                      ErrClr,
    input  logic                      ParOdd,
    output logic [DATA_BITS-1:0]      RxWData,
    output logic                      RxWen,
    output logic                      FrameErr,
    output logic                      Overrun,
    output logic                      ParityErr,
    output logic                      Busy
);

    localparam int SC_W = $clog2(OVERSAMPLE);
    localparam int BI_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [SC_W-1:0] SC_MID  = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
    localparam logic [BI_W-1:0] BI_LAST = BI_W'(DATA_BITS - 1);

    rx_state_t            r_state;
    rx_state_t            w_state_nxt;
    logic [1:0]           r_sync;
    logic                 r_rxd_d;
    logic                 w_rxd_s;
    logic                 w_fall;
    logic                 w_tick_en;
    logic                 w_tick;
    logic [SC_W-1:0]      r_sc;
    logic [BI_W-1:0]      r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_wdata;
    logic                 r_wen;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic                 w_shift_en;
    logic                 w_push;
    logic                 w_set_fe;
    logic                 w_set_ov;
    logic                 w_par_bad;
`ifdef UART_RX_PARITY_EN
    logic                 w_set_pe;
    logic                 r_par_bad;
    logic                 r_parity_err;
`else
    logic                 w_unused_parodd;
`endif

    // Two-flop synchroniser; idle-high reset value avoids a false start edge
    always_ff @(posedge UCLK or posedge reset) begin
        if (reset) begin
            r_sync  <= 2'b11;
            r_rxd_d <= 1'b1;
        end else begin
            r_sync  <= {r_sync[0], RxD};
            r_rxd_d <= w_rxd_s;
        end
    end

    assign w_rxd_s   = r_sync[1];
    assign w_fall    = r_rxd_d & ~w_rxd_s;
    assign w_tick_en = RxEn && (r_state != RX_IDLE);

    uart_baud_tick #(
        .DIV_W (BAUD_DIV_WIDTH)
    ) u_baud_tick (
        .i_clk  (UCLK),
        .i_rst  (reset),
        .i_en   (w_tick_en),
        .i_div  (BaudDiv),
        .o_tick (w_tick)
    );

    always_ff @(posedge UCLK or posedge reset) begin
        if (reset) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_push      = 1'b0;
        w_set_fe    = 1'b0;
        w_set_ov    = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_set_pe    = 1'b0;
`endif
        if (!RxEn) begin
            w_state_nxt = RX_IDLE;
        end else begin
            case (r_state)
                RX_IDLE: begin
                    if (w_fall) w_state_nxt = RX_START;
                end
                RX_START: begin
                    if (w_tick && r_sc == SC_MID)
                        w_state_nxt = w_rxd_s ? RX_IDLE : RX_DATA;
                end
                RX_DATA: begin
                    if (w_tick && r_sc == SC_LAST) begin
                        w_shift_en = 1'b1;
                        if (r_bit == BI_LAST) begin
`ifdef UART_RX_PARITY_EN
                            w_state_nxt = RX_PARITY;
`else
                            w_state_nxt = RX_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                RX_PARITY: begin
                    if (w_tick && r_sc == SC_LAST) begin
                        w_set_pe    = (w_rxd_s != ((^r_shift) ^ ParOdd));
                        w_state_nxt = RX_STOP;
                    end
                end
`endif
                RX_STOP: begin
                    // Leaving at mid stop bit lets the next start edge follow directly
                    if (w_tick && r_sc == SC_LAST) begin
                        if (!w_rxd_s) begin
                            w_set_fe    = 1'b1;
                            w_state_nxt = RX_BREAK;
                        end else begin
                            w_state_nxt = RX_IDLE;
                            if (w_par_bad) begin
                                w_push = 1'b0;
                            end else if (RxFull) begin
                                w_set_ov = 1'b1;
                            end else begin
                                w_push = 1'b1;
                            end
                        end
                    end
                end
                RX_BREAK: begin
                    if (w_rxd_s) w_state_nxt = RX_IDLE;
                end
                default: w_state_nxt = RX_IDLE;
            endcase
        end
    end

    // Sample counter restarts on every state change so each phase is timed from its entry
    always_ff @(posedge UCLK or posedge reset) begin
        if (reset) begin
            r_sc  <= '0;
            r_bit <= '0;
        end else begin
            if (r_state == RX_IDLE || w_state_nxt != r_state) begin
                r_sc <= '0;
            end else if (w_tick) begin
                r_sc <= (r_sc == SC_LAST) ? '0 : r_sc + 1'b1;
            end
            if (r_state != RX_DATA) begin
                r_bit <= '0;
            end else if (w_shift_en) begin
                r_bit <= r_bit + 1'b1;
            end
        end
    end

    always_ff @(posedge UCLK) begin
        if (w_shift_en) begin
            r_shift <= {w_rxd_s, r_shift[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge UCLK or posedge reset) begin
        if (reset) begin
            r_wdata     <= '0;
            r_wen       <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_wen <= w_push;
            if (w_push) r_wdata <= r_shift;
            if (w_set_fe)    r_frame_err <= 1'b1;
            else if (ErrClr) r_frame_err <= 1'b0;
            if (w_set_ov)    r_overrun <= 1'b1;
            else if (ErrClr) r_overrun <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge UCLK or posedge reset) begin
        if (reset) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (r_state == RX_IDLE) r_par_bad <= 1'b0;
            else if (w_set_pe)      r_par_bad <= 1'b1;
            if (w_set_pe)    r_parity_err <= 1'b1;
            else if (ErrClr) r_parity_err <= 1'b0;
        end
    end

    assign w_par_bad = r_par_bad;
    assign ParityErr = r_parity_err;
`else
    assign w_par_bad       = 1'b0;
    assign ParityErr       = 1'b0;
    assign w_unused_parodd = ParOdd;
`endif

    assign RxWData  = r_wdata;
    assign RxWen    = r_wen;
    assign FrameErr = r_frame_err;
    assign Overrun  = r_overrun;
    assign Busy     = (r_state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Self-checking bench for uart_rx_deser: table-driven frames plus hand-written
// sequences, with a byte scoreboard fed by a RxWen monitor.
module tb_uart_rx_deser;

    localparam int BIT = 64;  // BaudDiv=3 -> 4 UCLK per tick, 16 ticks per bit

    logic        UCLK = 1'b0;
    logic        reset = 1'b1;
    logic        RxEn = 1'b0;
    logic [19:0] BaudDiv = 20'd3;
    logic        RxD = 1'b1;
    logic        RxFull = 1'b0;
    logic        ErrClr = 1'b0;
    logic        ParOdd = 1'b0;
    logic [7:0]  RxWData;
    logic        RxWen;
    logic        FrameErr;
    logic        Overrun;
    logic        ParityErr;
    logic        Busy;

    uart_rx_deser dut (
        .UCLK      (UCLK),
        .reset     (reset),
        .RxEn      (RxEn),
        .BaudDiv   (BaudDiv),
        .RxD       (RxD),
        .RxFull    (RxFull),
        .ErrClr    (ErrClr),
        .ParOdd    (ParOdd),
        .RxWData   (RxWData),
        .RxWen     (RxWen),
        .FrameErr  (FrameErr),
        .Overrun   (Overrun),
        .ParityErr (ParityErr),
        .Busy      (Busy)
    );

    always #5 UCLK = ~UCLK;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       full;
        logic       clr;
        logic       push;
        logic       fe;
        logic       ov;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] last_push = 8'h00;
    int         checks = 0;
    int         failures = 0;

    always @(negedge UCLK) begin
        if (RxWen) got_q.push_back(RxWData);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge UCLK);
    endtask

    task automatic drive_bit(input logic b);
        RxD = b;
        cycles(BIT);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ ParOdd ^ par_flip);
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        drive_bit(stop);
    endtask

    task automatic pulse_clr();
        ErrClr = 1'b1;
        cycles(1);
        ErrClr = 1'b0;
        cycles(1);
    endtask

    task automatic check_sb(input string name);
        logic [7:0] e;
        logic [7:0] g;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() == 0) begin
                chk({name, "_missing_push"}, 32'h0, 32'(e));
            end else begin
                g = got_q.pop_front();
                chk({name, "_data"}, 32'(g), 32'(e));
                last_push = e;
            end
        end
        chk({name, "_extra_pushes"}, 32'(got_q.size()), 32'd0);
        got_q.delete();
        chk({name, "_wdata_hold"}, 32'(RxWData), 32'(last_push));
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'hC3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset state, both during and after reset
        cycles(3);
        chk("rst_outputs", {RxWData, RxWen, FrameErr, Overrun, ParityErr, Busy}, 32'h0);
        reset = 1'b0;
        cycles(2);
        chk("post_rst_outputs", {RxWData, RxWen, FrameErr, Overrun, ParityErr, Busy}, 32'h0);
        RxEn = 1'b1;
        cycles(10);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].clr) begin
                pulse_clr();
                chk($sformatf("v%0d_errclr", i), {FrameErr, Overrun, ParityErr}, 32'h0);
            end
            RxFull = vecs[i].full;
            if (vecs[i].push) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop, 1'b0);
            if (!vecs[i].stop) begin
                cycles(200 - BIT);
                chk($sformatf("v%0d_busy_break", i), 32'(Busy), 32'h1);
                RxD = 1'b1;
            end
            cycles(16);
            RxFull = 1'b0;
            chk($sformatf("v%0d_frame_err", i), 32'(FrameErr), 32'(vecs[i].fe));
            chk($sformatf("v%0d_overrun", i), 32'(Overrun), 32'(vecs[i].ov));
            chk($sformatf("v%0d_parity_err", i), 32'(ParityErr), 32'h0);
            chk($sformatf("v%0d_busy_idle", i), 32'(Busy), 32'h0);
            check_sb($sformatf("v%0d", i));
        end

        // False start: low for 20 UCLK only
        RxD = 1'b0;
        cycles(10);
        chk("false_start_busy", 32'(Busy), 32'h1);
        cycles(10);
        RxD = 1'b1;
        cycles(100);
        chk("false_start_idle", 32'(Busy), 32'h0);
        chk("false_start_flags", {FrameErr, Overrun, ParityErr}, 32'h0);
        check_sb("false_start");

        // Back-to-back frames with no idle gap
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        cycles(16);
        check_sb("back_to_back");

        // RxEn dropped mid-frame, then a clean frame
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        cycles(BIT / 2);
        chk("rxen_busy_before_drop", 32'(Busy), 32'h1);
        RxEn = 1'b0;
        cycles(2);
        chk("rxen_drop_idle", 32'(Busy), 32'h0);
        RxD = 1'b1;
        cycles(BIT * 4);
        RxEn = 1'b1;
        cycles(10);
        exp_q.push_back(8'h77);
        send_frame(8'h77, 1'b1, 1'b0);
        cycles(16);
        chk("rxen_drop_flags", {FrameErr, Overrun, ParityErr}, 32'h0);
        check_sb("rxen_drop");

`ifdef UART_RX_PARITY_EN
        // Odd parity: wrong bit then correct bit
        ParOdd = 1'b1;
        send_frame(8'h03, 1'b1, 1'b1);
        cycles(16);
        chk("par_bad_flag", 32'(ParityErr), 32'h1);
        chk("par_bad_fe", 32'(FrameErr), 32'h0);
        check_sb("par_bad");
        exp_q.push_back(8'h03);
        send_frame(8'h03, 1'b1, 1'b0);
        cycles(16);
        chk("par_good_sticky", 32'(ParityErr), 32'h1);
        check_sb("par_good");
        pulse_clr();
        chk("par_clr", 32'(ParityErr), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
